// File: rtl/fir_interp_stream_if.sv
// AXI-Stream style sample channel shared by the input and output sides of the interpolator.
interface fir_interp_stream_if #(
  parameter int unsigned DW = 24
) ();
  logic          tvalid;
  logic          tready;
  logic [DW-1:0] tdata;

  // Source side drives valid/data, sink side drives ready.
  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/fir_interp_stream.sv
// Polyphase FIR interpolator: INTERP outputs per accepted input, zero-stuff + FIR equivalent,
// gain-corrected by the polyphase shift, rounded half-up and saturated to DW bits.
module fir_interp_stream #(
  parameter int unsigned DW     = 24,
  parameter int unsigned TAPS   = 16,
  parameter int unsigned INTERP = 2,
  parameter int unsigned CW     = 16,
  parameter real         COEF [TAPS] = '{default: 0.0625}
) (
  input  logic                 clk,
  input  logic                 rst,
  fir_interp_stream_if.slave   s_axis,
  fir_interp_stream_if.master  m_axis
);

  localparam int unsigned L      = TAPS / INTERP;
  localparam int unsigned GS     = $clog2(INTERP);
  localparam int unsigned TIW    = $clog2(TAPS);
  localparam int unsigned AW     = DW + CW + $clog2(L) + 2;
  localparam int unsigned SH     = CW - 1 - GS;
  localparam int unsigned RND_SH = CW - 2 - GS;
  localparam logic [GS-1:0] P_LAST = GS'(INTERP - 1);
  localparam logic signed [AW-1:0] MAXV = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  // Round-to-nearest quantisation of a real coefficient, clamped to the signed CW range.
  function automatic int quant(input real c);
    real s;
    int  q;
    s = c * (2.0 ** (CW - 1));
    q = (s >= 0.0) ? $rtoi(s + 0.5) : -$rtoi(0.5 - s);
    if (q > (2 ** (CW - 1)) - 1) q = (2 ** (CW - 1)) - 1;
    if (q < -(2 ** (CW - 1)))    q = -(2 ** (CW - 1));
    return q;
  endfunction

  typedef enum logic [0:0] {IDLE, EMIT} state_t;

  state_t                 state;
  logic [GS-1:0]          p;
  logic signed [DW-1:0]   dl    [L];
  logic signed [DW-1:0]   dl_sh [L];
  logic signed [CW-1:0]   hq    [TAPS];
  logic [GS-1:0]          ph;
  logic [TIW-1:0]         idx;
  logic signed [DW-1:0]   src;
  logic signed [AW-1:0]   acc;
  logic signed [AW-1:0]   acc_r;
  logic signed [AW-1:0]   y_sh;
  logic signed [DW-1:0]   y;
  logic                   s_en;
  logic                   m_en;

  // Quantised coefficient table, fixed at elaboration.
  for (genvar j = 0; j < int'(TAPS); j++) begin : g_hq
    localparam int Q = quant(COEF[j]);
    assign hq[j] = CW'(Q);
  end

  // Ready when idle, or when the last phase is leaving this cycle (no bubble between inputs).
  assign s_axis.tready = !rst && (state == IDLE || (p == P_LAST && m_axis.tready));
  assign s_en = s_axis.tvalid && s_axis.tready;
  assign m_en = m_axis.tvalid && m_axis.tready;

  // Delay line as it would look after accepting the sample on the input.
  always_comb begin
    dl_sh[0] = $signed(s_axis.tdata);
    for (int k = 1; k < int'(L); k++) dl_sh[k] = dl[k-1];
  end

  // Phase MAC: phase 0 on the shifted line for a new sample, otherwise the next phase.
  always_comb begin
    acc = '0;
    idx = '0;
    src = '0;
    ph  = s_en ? '0 : GS'(p + GS'(1));
    for (int k = 0; k < int'(L); k++) begin
      idx = TIW'(ph) + TIW'(k * int'(INTERP));
      src = s_en ? dl_sh[k] : dl[k];
      acc = acc + AW'(src) * AW'(hq[idx]);
    end
    acc_r = acc + (AW'(1) <<< RND_SH);
    y_sh  = acc_r >>> SH;
  end

  // Clamp the rescaled sum to the output range.
  always_comb begin
    if (y_sh > MAXV)      y = DW'(MAXV);
    else if (y_sh < MINV) y = DW'(MINV);
    else                  y = DW'(y_sh);
  end

  // Control FSM with registered output channel; stalls hold everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      p             <= '0;
      m_axis.tvalid <= 1'b0;
      m_axis.tdata  <= '0;
      for (int k = 0; k < int'(L); k++) dl[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (s_en) begin
            dl            <= dl_sh;
            p             <= '0;
            m_axis.tdata  <= y;
            m_axis.tvalid <= 1'b1;
            state         <= EMIT;
          end
        end
        EMIT: begin
          if (m_en) begin
            if (p != P_LAST) begin
              p            <= p + GS'(1);
              m_axis.tdata <= y;
            end else if (s_en) begin
              dl           <= dl_sh;
              p            <= '0;
              m_axis.tdata <= y;
            end else begin
              m_axis.tvalid <= 1'b0;
              state         <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_interp_stream.sv
// Scoreboard bench for fir_interp_stream: directed vectors, queue-based output checking.
module tb_fir_interp_stream;
  localparam int unsigned DW = 24;
  localparam real CA [4] = '{0.125, 0.25, 0.375, 0.5};
  localparam real CB [4] = '{default: 0.9};
  localparam logic [DW-1:0] X = 24'h100000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  fir_interp_stream_if #(.DW(DW)) a_s ();
  fir_interp_stream_if #(.DW(DW)) a_m ();
  fir_interp_stream_if #(.DW(DW)) b_s ();
  fir_interp_stream_if #(.DW(DW)) b_m ();

  fir_interp_stream #(.DW(DW), .TAPS(4), .INTERP(2), .CW(16), .COEF(CA)) dut (
    .clk(clk), .rst(rst), .s_axis(a_s), .m_axis(a_m));

  fir_interp_stream #(.DW(DW), .TAPS(4), .INTERP(2), .CW(16), .COEF(CB)) dut_sat (
    .clk(clk), .rst(rst_b), .s_axis(b_s), .m_axis(b_m));

  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] qa [$];
  logic [DW-1:0] qb [$];
  int cyc = 0;
  int rdy_mode = 0;
  int bp_cnt = 0;
  int hs_cyc = 0;
  int n_in_a = 0;
  int n_out_a = 0;
  logic t5_active = 1'b0;
  int t5_gaps = 0;
  logic prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  // Impulse, then DC, then zero flush: reference sequence shared by several tests.
  logic [DW-1:0] seq_in [9] = '{X, 24'd0, 24'd0, X, X, X, X, 24'd0, 24'd0};
  logic [DW-1:0] seq_exp [18] = '{
    24'd262144, 24'd524288, 24'd786432, 24'd1048576, 24'd0, 24'd0,
    24'd262144, 24'd524288, 24'd1048576, 24'd1572864, 24'd1048576, 24'd1572864,
    24'd1048576, 24'd1572864, 24'd786432, 24'd1048576, 24'd0, 24'd0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", name, act, act, exp, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready: always, random with a forced 5-cycle stall, or held low.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: a_m.tready = 1'b1;
      1: begin
        bp_cnt++;
        a_m.tready = (bp_cnt >= 5 && bp_cnt < 10) ? 1'b0 : 1'($urandom_range(0, 1));
      end
      default: a_m.tready = 1'b0;
    endcase
  end

  // Monitor A: scoreboard pop, stall stability and throughput gap tracking.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(a_m.tvalid), 32'd1);
        check("hold_data", 32'(a_m.tdata), 32'(prev_data));
      end
      if (a_m.tvalid && !a_m.tready) check("stall_sready", 32'(a_s.tready), 32'd0);
      if (t5_active && !a_m.tvalid) t5_gaps++;
      if (a_m.tvalid && a_m.tready) begin
        n_out_a++;
        if (qa.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL extra_out_a: got 0x%h, expected no output", a_m.tdata);
        end else begin
          check("out_a", 32'(a_m.tdata), 32'(qa.pop_front()));
        end
        if (qa.size() == 0) t5_active = 1'b0;
      end
      prev_stall = a_m.tvalid && !a_m.tready;
      prev_data  = a_m.tdata;
    end
  end

  // Monitor B: saturation instance scoreboard.
  always @(negedge clk) begin
    if (!rst_b && b_m.tvalid && b_m.tready) begin
      if (qb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL extra_out_b: got 0x%h, expected no output", b_m.tdata);
      end else begin
        check("out_b", 32'(b_m.tdata), 32'(qb.pop_front()));
      end
    end
  end

  task automatic send_a(input logic [DW-1:0] x);
    int t;
    a_s.tdata  = x;
    a_s.tvalid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!a_s.tready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!a_s.tready) check("send_a_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    hs_cyc = cyc;
    n_in_a++;
    a_s.tvalid = 1'b0;
  endtask

  task automatic send_b(input logic [DW-1:0] x);
    int t;
    b_s.tdata  = x;
    b_s.tvalid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!b_s.tready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!b_s.tready) check("send_b_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    b_s.tvalid = 1'b0;
  endtask

  task automatic run_seq(input int n, input int gap, input bit lat, input bit t5);
    int first_hs;
    first_hs = 0;
    for (int i = 0; i < n; i++) begin
      qa.push_back(seq_exp[2*i]);
      qa.push_back(seq_exp[2*i+1]);
      send_a(seq_in[i]);
      if (i == 0) begin
        first_hs = hs_cyc;
        if (lat) check("latency_valid", 32'(a_m.tvalid), 32'd1);
        if (t5) begin
          t5_gaps   = 0;
          t5_active = 1'b1;
        end
      end
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
    if (t5) check("t5_hs_span", 32'(hs_cyc - first_hs), 32'(2 * (n - 1)));
  endtask

  task automatic drain_a();
    int t;
    t = 0;
    while (qa.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    check("drain_a", 32'(qa.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic drain_b();
    int t;
    t = 0;
    while (qb.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    check("drain_b", 32'(qb.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    a_s.tvalid = 1'b0;
    a_s.tdata  = '0;
    b_s.tvalid = 1'b0;
    b_s.tdata  = '0;
    b_m.tready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sready", 32'(a_s.tready), 32'd0);
    check("rst_mvalid", 32'(a_m.tvalid), 32'd0);
    check("rst_mdata", 32'(a_m.tdata), 32'd0);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    rst_b = 1'b0;
    #1;
    check("idle_sready", 32'(a_s.tready), 32'd1);
    @(posedge clk);
    #1;

    // T1/T2: impulse, DC, flush with idle gaps between inputs
    run_seq(9, 2, 1'b1, 1'b0);
    drain_a();

    // T3: random backpressure including a 5-cycle stall
    bp_cnt   = 0;
    rdy_mode = 1;
    run_seq(9, 0, 1'b0, 1'b0);
    drain_a();
    rdy_mode = 0;
    @(posedge clk);
    #2;

    // T5: back-to-back throughput
    run_seq(9, 0, 1'b0, 1'b1);
    drain_a();
    check("t5_gaps", 32'(t5_gaps), 32'd0);

    // T6: reset while phase 0 is pending
    rdy_mode = 2;
    @(posedge clk);
    #2;
    send_a(X);
    check("t6_pre_valid", 32'(a_m.tvalid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_sready", 32'(a_s.tready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t6_valid", 32'(a_m.tvalid), 32'd0);
    check("t6_data", 32'(a_m.tdata), 32'd0);
    rdy_mode = 0;
    @(posedge clk);
    #2;
    run_seq(3, 1, 1'b1, 1'b0);
    drain_a();
    check("io_ratio", 32'(n_out_a), 32'(2 * (n_in_a - 1)));

    // T4: saturation on both rails
    for (int i = 0; i < 3; i++) begin
      qb.push_back(24'h7FFFFF);
      qb.push_back(24'h7FFFFF);
      send_b(24'h7FFFFF);
    end
    drain_b();
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      qb.push_back(24'h800000);
      qb.push_back(24'h800000);
      send_b(24'h800000);
    end
    drain_b();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
